soa_ptr_bank: RTL

SOA_PTR_BANK -- requirements
Module: soa_ptr_bank

---
 rtl/soa_ptr_pkg.sv | 16 +
 rtl/soa_ptr_step.sv | 56 +++++
 rtl/soa_ptr_bank.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/soa_ptr_pkg.sv
// Shared command and FSM encodings for the pointer bank.
package soa_ptr_pkg;

    typedef enum logic [1:0] {
        OP_SET   = 2'd0,
        OP_ADD   = 2'd1,
        OP_SUB   = 2'd2,
        OP_SWEEP = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/soa_ptr_step.sv
// Combinational next value of one pointer channel: set, add or subtract with
// either modular wrap or saturation at 0 / PTR_MAX.
module soa_ptr_step
    import soa_ptr_pkg::*;
#(
    parameter int PTR_W   = 5,
    parameter int PTR_MAX = 2**PTR_W - 1
) (
    input  logic [PTR_W-1:0] ptr_i,
    input  logic [1:0]       op_i,
    input  logic [PTR_W-1:0] arg_i,
    input  logic             wrap_i,
    output logic [PTR_W-1:0] nxt_o,
    output logic             ovf_o
);

    localparam logic [PTR_W:0] MAX_W = (PTR_W+1)'(PTR_MAX);
    localparam logic [PTR_W:0] MOD_W = (PTR_W+1)'(PTR_MAX + 1);

    logic [PTR_W:0] ptr_ext;
    logic [PTR_W:0] arg_ext;
    logic [PTR_W:0] arg_m;
    logic [PTR_W:0] sum;

    // Step amounts beyond the pointer range are folded back into it first.
    assign ptr_ext = {1'b0, ptr_i};
    assign arg_ext = {1'b0, arg_i};
    assign arg_m   = arg_ext % MOD_W;
    assign sum     = ptr_ext + arg_m;

    always_comb begin
        nxt_o = ptr_i;
        ovf_o = 1'b0;
        case (op_e'(op_i))
            OP_SET: nxt_o = (arg_ext > MAX_W) ? MAX_W[PTR_W-1:0] : arg_i;
            OP_ADD: begin
                if (sum > MAX_W) begin
                    ovf_o = 1'b1;
                    nxt_o = wrap_i ? PTR_W'(sum - MOD_W) : MAX_W[PTR_W-1:0];
                end else begin
                    nxt_o = sum[PTR_W-1:0];
                end
            end
            OP_SUB: begin
                if (arg_m > ptr_ext) begin
                    ovf_o = 1'b1;
                    nxt_o = wrap_i ? PTR_W'(ptr_ext + MOD_W - arg_m) : '0;
                end else begin
                    nxt_o = PTR_W'(ptr_ext - arg_m);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/soa_ptr_bank.sv
// Bank of NUM_CH independent pointers driven by set/add/sub commands plus a
// sweep engine that walks one channel towards a target, one step per cycle.
module soa_ptr_bank
    import soa_ptr_pkg::*;
#(
    parameter int PTR_W     = 5,
    parameter int NUM_CH    = 4,
    parameter int PTR_MAX   = 2**PTR_W - 1,
    parameter int RESET_VAL = 0
) (
    input  logic                                           Clk,
    input  logic                                           Reset,
    input  logic                                           cmd_valid,
    output logic                                           cmd_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cmd_ch,
    input  logic [1:0]                                     cmd_op,
    input  logic [PTR_W-1:0]                               cmd_arg,
    input  logic [NUM_CH-1:0]                              wrap_en,
    output logic [NUM_CH*PTR_W-1:0]                        ptr_out,
    output logic [NUM_CH-1:0]                              at_max,
    output logic [NUM_CH-1:0]                              ovf,
    output logic                                           sweep_done
);

    localparam int             CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PTR_W:0] MAX_W = (PTR_W+1)'(PTR_MAX);

    function automatic logic [PTR_W-1:0] clamp_max(input logic [PTR_W-1:0] v);
        return ({1'b0, v} > MAX_W) ? MAX_W[PTR_W-1:0] : v;
    endfunction

    state_e           state_q, state_d;
    logic [CH_W-1:0]  swp_ch_q, swp_ch_d;
    logic [PTR_W-1:0] swp_tgt_q, swp_tgt_d;
    logic             done_q, done_d;

    op_e              cmd_op_e;
    logic             accept;
    logic             ch_ok;
    logic [PTR_W-1:0] cur_a [NUM_CH];
    logic [PTR_W-1:0] nxt_a [NUM_CH];
    logic [NUM_CH-1:0] step_ovf_a;

    assign cmd_op_e   = op_e'(cmd_op);
    assign cmd_ready  = (state_q == ST_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign ch_ok      = (int'(cmd_ch) < NUM_CH);
    assign sweep_done = done_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             en;
        logic [1:0]       op;
        logic [PTR_W-1:0] arg;
        logic [PTR_W-1:0] nxt;
        logic             step_ovf;
        logic [PTR_W-1:0] ptr_q, ptr_d;
        logic             ovf_q, at_max_q;

        // A sweeping channel is stepped as ADD 1 under its own wrap rule.
        always_comb begin
            en  = 1'b0;
            op  = OP_ADD;
            arg = PTR_W'(1);
            if (state_q == ST_SWEEP) begin
                en = (swp_ch_q == CH_W'(g));
            end else if (accept && (cmd_ch == CH_W'(g)) && (cmd_op_e != OP_SWEEP)) begin
                en  = 1'b1;
                op  = cmd_op;
                arg = cmd_arg;
            end
        end

        soa_ptr_step #(
            .PTR_W   (PTR_W),
            .PTR_MAX (PTR_MAX)
        ) u_step (
            .ptr_i  (ptr_q),
            .op_i   (op),
            .arg_i  (arg),
            .wrap_i (wrap_en[g]),
            .nxt_o  (nxt),
            .ovf_o  (step_ovf)
        );

        assign ptr_d = en ? nxt : ptr_q;

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                ptr_q    <= PTR_W'(RESET_VAL);
                ovf_q    <= 1'b0;
                at_max_q <= (RESET_VAL == PTR_MAX);
            end else begin
                ptr_q    <= ptr_d;
                ovf_q    <= en && step_ovf;
                at_max_q <= ({1'b0, ptr_d} == MAX_W);
            end
        end

        assign ptr_out[g*PTR_W +: PTR_W] = ptr_q;
        assign ovf[g]                    = ovf_q;
        assign at_max[g]                 = at_max_q;
        assign cur_a[g]                  = ptr_q;
        assign nxt_a[g]                  = nxt;
        assign step_ovf_a[g]             = step_ovf;
    end

    // A saturating channel that cannot climb further ends the sweep without done.
    always_comb begin
        state_d   = state_q;
        swp_ch_d  = swp_ch_q;
        swp_tgt_d = swp_tgt_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && (cmd_op_e == OP_SWEEP) && ch_ok) begin
                    if (cur_a[cmd_ch] == clamp_max(cmd_arg)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ST_SWEEP;
                        swp_ch_d  = cmd_ch;
                        swp_tgt_d = clamp_max(cmd_arg);
                    end
                end
            end
            ST_SWEEP: begin
                if (nxt_a[swp_ch_q] == swp_tgt_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (step_ovf_a[swp_ch_q] && !wrap_en[swp_ch_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            swp_ch_q  <= '0;
            swp_tgt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            swp_ch_q  <= swp_ch_d;
            swp_tgt_q <= swp_tgt_d;
            done_q    <= done_d;
        end
    end

endmodule
